mem_port_arbiter: RTL

Shares the single 32-bit instruction/data memory port between the fetch unit and the load/store unit (LSU). It sits between both requesters and the memory, with one transaction outstanding at a time. LSU traffic has priority, and a streak limit guarantees fetch forward progress. A flush input discards in-flight fetch responses after a control transfer, and a watchdog aborts memory transactions that never complete.

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/mem_arb_watchdog.sv | 39 +++
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/LSU memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned STREAK_W = 4;
    localparam int unsigned TIMER_W  = 8;
    localparam int unsigned ADDR_W   = 30;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BE_W     = 4;

    localparam logic [BE_W-1:0] ALL_BYTES = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    // Command presented on the memory port for the duration of a transaction.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_cmd_t;

    function automatic logic [STREAK_W-1:0] streak_inc(
        input logic [STREAK_W-1:0] cur,
        input logic [STREAK_W-1:0] lim
    );
        return (cur >= lim) ? lim : cur + STREAK_W'(1);
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Loadable down-counter that flags a memory transaction stuck past its budget.
module mem_arb_watchdog
    import mem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               en,
    output logic               expire_c
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    // Last budgeted cycle: the count was loaded with the full budget at grant.
    assign expire_c = en && (count_q == TIMER_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU; LSU has
// priority, bounded by a streak limit, with flush-drop and a timeout watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              ins_req,
    input  logic [ADDR_W-1:0] ins_addr,
    input  logic              ins_flush,
    output logic              ins_res,
    output logic [DATA_W-1:0] ins_data,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [BE_W-1:0]   lsu_be,
    output logic              lsu_ack,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [TIMER_W-1:0]  TIMER_INIT = TIMER_W'(TIMEOUT);

    arb_state_t          state_q,     state_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic                drop_q,      drop_d;
    mem_cmd_t            cmd_q,       cmd_d;
    logic                mem_req_q,   mem_req_d;
    logic                ins_done_q,  ins_done_d;
    logic [DATA_W-1:0]   ins_data_q,  ins_data_d;
    logic                lsu_ack_q,   lsu_ack_d;
    logic                lsu_err_q,   lsu_err_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;

    logic wd_load_c;
    logic wd_clr_c;
    logic wd_en_c;
    logic wd_expire_c;
    logic lsu_win_c;

    // LSU wins unless fetch is waiting and has already been passed over too often.
    assign lsu_win_c = lsu_req && !(ins_req && (streak_q == STREAK_MAX));
    assign wd_en_c   = (state_q != IDLE);

    mem_arb_watchdog u_watchdog (
        .clk      (cpu_clk),
        .rst      (cpu_rst),
        .clr      (wd_clr_c),
        .load     (wd_load_c),
        .load_val (TIMER_INIT),
        .en       (wd_en_c),
        .expire_c (wd_expire_c)
    );

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        drop_d      = drop_q;
        cmd_d       = cmd_q;
        mem_req_d   = mem_req_q;
        ins_done_d  = 1'b0;
        ins_data_d  = ins_data_q;
        lsu_ack_d   = 1'b0;
        lsu_err_d   = 1'b0;
        lsu_rdata_d = lsu_rdata_q;
        wd_load_c   = 1'b0;
        wd_clr_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (lsu_win_c) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    cmd_d.we    = lsu_we;
                    cmd_d.addr  = lsu_addr;
                    cmd_d.wdata = lsu_wdata;
                    cmd_d.be    = lsu_be;
                    wd_load_c   = 1'b1;
                    streak_d    = ins_req ? streak_inc(streak_q, STREAK_MAX) : '0;
                end else if (ins_req) begin
                    state_d     = BUSY_F;
                    mem_req_d   = 1'b1;
                    cmd_d.we    = 1'b0;
                    cmd_d.addr  = ins_addr;
                    cmd_d.wdata = '0;
                    cmd_d.be    = ALL_BYTES;
                    wd_load_c   = 1'b1;
                    streak_d    = '0;
                end
            end

            BUSY_F: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    cmd_d.we   = 1'b0;
                    ins_data_d = mem_rdata;
                    ins_done_d = !(drop_q || ins_flush);
                    drop_d     = 1'b0;
                    wd_clr_c   = 1'b1;
                end else if (wd_expire_c) begin
                    // Aborted fetch is dropped silently; the held ins_req retries it.
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    cmd_d.we  = 1'b0;
                    drop_d    = 1'b0;
                    wd_clr_c  = 1'b1;
                end else if (ins_flush) begin
                    drop_d = 1'b1;
                end
            end

            BUSY_D: begin
                if (mem_ack) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    cmd_d.we    = 1'b0;
                    lsu_ack_d   = 1'b1;
                    lsu_rdata_d = mem_rdata;
                    wd_clr_c    = 1'b1;
                end else if (wd_expire_c) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    cmd_d.we    = 1'b0;
                    lsu_ack_d   = 1'b1;
                    lsu_err_d   = 1'b1;
                    lsu_rdata_d = '0;
                    wd_clr_c    = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            drop_q      <= 1'b0;
            cmd_q       <= '0;
            mem_req_q   <= 1'b0;
            ins_done_q  <= 1'b0;
            ins_data_q  <= '0;
            lsu_ack_q   <= 1'b0;
            lsu_err_q   <= 1'b0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            drop_q      <= drop_d;
            cmd_q       <= cmd_d;
            mem_req_q   <= mem_req_d;
            ins_done_q  <= ins_done_d;
            ins_data_q  <= ins_data_d;
            lsu_ack_q   <= lsu_ack_d;
            lsu_err_q   <= lsu_err_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    // A redirect during the response cycle still kills the fetch pulse.
    assign ins_res   = ins_done_q && !ins_flush;
    assign ins_data  = ins_data_q;
    assign lsu_ack   = lsu_ack_q;
    assign lsu_err   = lsu_err_q;
    assign lsu_rdata = lsu_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign mem_be    = cmd_q.be;

endmodule
